// File: rtl/rx_cmd_decoder.sv
// UART command decoder. It turns the received byte stream into register-file
// write/read requests and ALU operations, with error, abort and timeout handling.
module rx_cmd_decoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  input  logic                  RD_DATA_VLD,
  input  logic                  ALU_OUT_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  ALU_EN,
  output logic [FUN_WIDTH-1:0]  ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  BUSY,
  output logic                  CMD_ERR
);

  localparam int unsigned CNT_WIDTH = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  localparam logic [DATA_WIDTH-1:0] OP_WRITE   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_READ    = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_OPS = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NOP = DATA_WIDTH'(8'hDD);

  // ALU operands always land in registers 0 and 1
  localparam logic [ADDR_WIDTH-1:0] OPA_ADDR = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OPB_ADDR = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_OP_A,
    S_OP_B,
    S_ALU_FUN,
    S_ALU_WAIT
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;

  logic byte_ok_c;
  logic byte_bad_c;
  logic timeout_c;

  assign byte_ok_c  = RX_D_VLD & ~RX_ERR;
  assign byte_bad_c = RX_D_VLD & RX_ERR;
  assign timeout_c  = (wait_cnt >= CNT_LAST);

  // Single-process FSM; every output is a register, pulses default low each cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      WrEn        <= 1'b0;
      RdEn        <= 1'b0;
      Address     <= '0;
      WrData      <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      BUSY        <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      ALU_EN  <= 1'b0;
      CMD_ERR <= 1'b0;

      if (byte_bad_c) begin
        // A corrupted byte aborts whatever command is in flight
        state       <= S_IDLE;
        BUSY        <= 1'b0;
        CLK_GATE_EN <= 1'b0;
        CMD_ERR     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (byte_ok_c) begin
              case (RX_P_DATA)
                OP_WRITE: begin
                  state <= S_WR_ADDR;
                  BUSY  <= 1'b1;
                end
                OP_READ: begin
                  state <= S_RD_ADDR;
                  BUSY  <= 1'b1;
                end
                OP_ALU_OPS: begin
                  state       <= S_OP_A;
                  BUSY        <= 1'b1;
                  CLK_GATE_EN <= 1'b1;
                end
                OP_ALU_NOP: begin
                  state       <= S_ALU_FUN;
                  BUSY        <= 1'b1;
                  CLK_GATE_EN <= 1'b1;
                end
                default: CMD_ERR <= 1'b1;
              endcase
            end
          end

          S_WR_ADDR: begin
            if (byte_ok_c) begin
              Address <= RX_P_DATA[ADDR_WIDTH-1:0];
              state   <= S_WR_DATA;
            end
          end

          S_WR_DATA: begin
            if (byte_ok_c) begin
              WrData <= RX_P_DATA;
              WrEn   <= 1'b1;
              state  <= S_IDLE;
              BUSY   <= 1'b0;
            end
          end

          S_RD_ADDR: begin
            if (byte_ok_c) begin
              Address  <= RX_P_DATA[ADDR_WIDTH-1:0];
              RdEn     <= 1'b1;
              wait_cnt <= '0;
              state    <= S_RD_WAIT;
            end
          end

          S_RD_WAIT: begin
            if (byte_ok_c) begin
              CMD_ERR <= 1'b1;
            end
            // A completion coincident with our own RdEn pulse cannot be ours
            if (RD_DATA_VLD && !RdEn) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end else if (timeout_c) begin
              state   <= S_IDLE;
              BUSY    <= 1'b0;
              CMD_ERR <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_WIDTH'(1);
            end
          end

          S_OP_A: begin
            if (byte_ok_c) begin
              Address <= OPA_ADDR;
              WrData  <= RX_P_DATA;
              WrEn    <= 1'b1;
              state   <= S_OP_B;
            end
          end

          S_OP_B: begin
            if (byte_ok_c) begin
              Address <= OPB_ADDR;
              WrData  <= RX_P_DATA;
              WrEn    <= 1'b1;
              state   <= S_ALU_FUN;
            end
          end

          S_ALU_FUN: begin
            if (byte_ok_c) begin
              ALU_FUN  <= RX_P_DATA[FUN_WIDTH-1:0];
              ALU_EN   <= 1'b1;
              wait_cnt <= '0;
              state    <= S_ALU_WAIT;
            end
          end

          S_ALU_WAIT: begin
            if (byte_ok_c) begin
              CMD_ERR <= 1'b1;
            end
            if (ALU_OUT_VLD) begin
              state       <= S_IDLE;
              BUSY        <= 1'b0;
              CLK_GATE_EN <= 1'b0;
            end else if (timeout_c) begin
              state       <= S_IDLE;
              BUSY        <= 1'b0;
              CLK_GATE_EN <= 1'b0;
              CMD_ERR     <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_WIDTH'(1);
            end
          end

          default: begin
            state       <= S_IDLE;
            BUSY        <= 1'b0;
            CLK_GATE_EN <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder: write, ALU, read timeout, read completion,
// RX error abort, bad opcode and mid-command reset, with hand-computed results.
module tb_rx_cmd_decoder;

  logic       CLK;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic       RX_ERR;
  logic       RD_DATA_VLD;
  logic       ALU_OUT_VLD;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_GATE_EN;
  logic       BUSY;
  logic       CMD_ERR;

  int errors = 0;
  int checks = 0;

  rx_cmd_decoder dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .RX_ERR      (RX_ERR),
    .RD_DATA_VLD (RD_DATA_VLD),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .WrEn        (WrEn),
    .RdEn        (RdEn),
    .Address     (Address),
    .WrData      (WrData),
    .ALU_EN      (ALU_EN),
    .ALU_FUN     (ALU_FUN),
    .CLK_GATE_EN (CLK_GATE_EN),
    .BUSY        (BUSY),
    .CMD_ERR     (CMD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; returns on the falling edge where its result is visible
  task automatic send_byte(input logic [7:0] b, input logic err);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    RX_ERR    = err;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    RX_ERR    = 1'b0;
  endtask

  task automatic pulse_rd_vld();
    @(negedge CLK);
    RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0;
  endtask

  task automatic pulse_alu_vld();
    @(negedge CLK);
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, {28'd0, WrEn, RdEn, ALU_EN, CMD_ERR}, 32'd0);
    check({tag, "_addr"}, 32'(Address), 32'd0);
    check({tag, "_wrdata"}, 32'(WrData), 32'd0);
    check({tag, "_alufun"}, 32'(ALU_FUN), 32'd0);
    check({tag, "_gate_busy"}, {30'd0, CLK_GATE_EN, BUSY}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    RST         = 1'b0;
    RX_P_DATA   = 8'h00;
    RX_D_VLD    = 1'b0;
    RX_ERR      = 1'b0;
    RD_DATA_VLD = 1'b0;
    ALU_OUT_VLD = 1'b0;

    #3;
    check_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // Write: AA 05 3C
    send_byte(8'hAA, 1'b0);
    check("wr_op_busy", 32'(BUSY), 32'd1);
    send_byte(8'h05, 1'b0);
    check("wr_addr_nopulse", 32'(WrEn), 32'd0);
    send_byte(8'h3C, 1'b0);
    check("wr_wren", 32'(WrEn), 32'd1);
    check("wr_addr", 32'(Address), 32'd5);
    check("wr_data", 32'(WrData), 32'h3C);
    check("wr_busy_low", 32'(BUSY), 32'd0);
    @(negedge CLK);
    check("wr_wren_one_cycle", 32'(WrEn), 32'd0);

    // Upper address bits dropped: 0x37 -> 7
    send_byte(8'hAA, 1'b0);
    send_byte(8'h37, 1'b0);
    send_byte(8'h99, 1'b0);
    check("wr2_addr_trunc", 32'(Address), 32'd7);
    check("wr2_data", 32'(WrData), 32'h99);

    // ALU with operands: CC 10 20 03
    send_byte(8'hCC, 1'b0);
    check("alu_gate_on", {30'd0, CLK_GATE_EN, BUSY}, 32'd3);
    send_byte(8'h10, 1'b0);
    check("opa", {23'd0, WrEn, Address, WrData}, {23'd0, 1'b1, 4'd0, 8'h10});
    send_byte(8'h20, 1'b0);
    check("opb", {23'd0, WrEn, Address, WrData}, {23'd0, 1'b1, 4'd1, 8'h20});
    send_byte(8'h03, 1'b0);
    check("alu_en", {27'd0, ALU_EN, ALU_FUN}, {27'd0, 1'b1, 4'd3});
    check("alu_fun_nowr", 32'(WrEn), 32'd0);
    repeat (3) @(negedge CLK);
    check("alu_wait_gate", {30'd0, CLK_GATE_EN, BUSY}, 32'd3);
    check("alu_en_one_cycle", 32'(ALU_EN), 32'd0);
    pulse_alu_vld();
    check("alu_done_gate", {30'd0, CLK_GATE_EN, BUSY}, 32'd0);
    check("alu_hold_addr_data", {20'd0, Address, WrData}, {20'd0, 4'd1, 8'h20});

    // Read timeout: BB 0A, no completion
    send_byte(8'hBB, 1'b0);
    send_byte(8'h0A, 1'b0);
    check("rd_rden", {27'd0, RdEn, Address}, {27'd0, 1'b1, 4'hA});
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 400 && !seen; k++) begin
      @(negedge CLK);
      if (k == 1) check("rd_rden_one_cycle", 32'(RdEn), 32'd0);
      if (CMD_ERR) begin
        seen = 1'b1;
        n = k;
      end
    end
    check("rd_timeout_cycles", 32'(n), 32'd255);
    check("rd_timeout_idle", 32'(BUSY), 32'd0);

    // Read with completion; completion coincident with RdEn is ignored
    send_byte(8'hBB, 1'b0);
    send_byte(8'h03, 1'b0);
    RD_DATA_VLD = 1'b1;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0;
    check("rd_early_vld_ignored", 32'(BUSY), 32'd1);
    send_byte(8'h77, 1'b0);
    check("rd_wait_byte_drop", {30'd0, CMD_ERR, BUSY}, 32'd3);
    pulse_rd_vld();
    check("rd_done", {30'd0, CMD_ERR, BUSY}, 32'd0);
    check("rd_addr", 32'(Address), 32'd3);

    // RX error abort, then ALU without operands
    send_byte(8'hAA, 1'b0);
    send_byte(8'h02, 1'b1);
    check("rxerr_abort", {29'd0, CMD_ERR, WrEn, BUSY}, 32'h4);
    check("rxerr_addr_hold", 32'(Address), 32'd3);
    send_byte(8'hDD, 1'b0);
    check("dd_gate", {30'd0, CLK_GATE_EN, BUSY}, 32'd3);
    send_byte(8'h01, 1'b0);
    check("dd_alu_en", {27'd0, ALU_EN, ALU_FUN}, {27'd0, 1'b1, 4'd1});
    pulse_alu_vld();
    check("dd_done", {30'd0, CLK_GATE_EN, BUSY}, 32'd0);

    // Bad opcode
    send_byte(8'h55, 1'b0);
    check("bad_op", {30'd0, CMD_ERR, BUSY}, 32'd2);

    // Reset during OP_B
    send_byte(8'hCC, 1'b0);
    send_byte(8'h10, 1'b0);
    check("pre_reset_gate", 32'(CLK_GATE_EN), 32'd1);
    #2;
    RST = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge CLK);
    RST = 1'b1;
    send_byte(8'h20, 1'b0);
    check("post_reset_no_wr", {30'd0, WrEn, CMD_ERR}, 32'd1);
    check("post_reset_idle", {30'd0, CLK_GATE_EN, BUSY}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
